// File: rtl/gpio_bank.sv
// gpio_bank: GPIO peripheral for the MicroBlaze MCS I/O bus. Inputs are
// synchronised and debounced. Outputs support full writes and per-bit
// set/clear. Debounced edges raise a maskable, W1C-latched interrupt.
module gpio_bank #(
    parameter int               N_IN            = 8,
    parameter int               N_OUT           = 8,
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter logic [N_OUT-1:0] OUT_RESET       = '0
) (
    input  logic             clk_fpga,
    input  logic             reset,
    input  logic             io_addr_strobe,
    input  logic             io_read_strobe,
    input  logic             io_write_strobe,
    input  logic [31:0]      io_address,
    input  logic [31:0]      io_write_data,
    output logic [31:0]      io_read_data,
    output logic             io_ready,
    input  logic [N_IN-1:0]  switchs,
    output logic [N_OUT-1:0] leds,
    output logic             irq
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Register select, taken from io_address[4:2].
    typedef enum logic [2:0] {
        A_OUT  = 3'd0,
        A_IN   = 3'd1,
        A_RISE = 3'd2,
        A_FALL = 3'd3,
        A_STAT = 3'd4,
        A_SET  = 3'd5,
        A_CLR  = 3'd6,
        A_NONE = 3'd7
    } reg_sel_e;

    logic [N_IN-1:0]  r_sync1;
    logic [N_IN-1:0]  r_sync2;
    logic [N_IN-1:0]  r_stable;
    logic [N_IN-1:0]  r_prev;
    logic [CW-1:0]    r_cnt [N_IN];
    logic [N_IN-1:0]  r_rise_en;
    logic [N_IN-1:0]  r_fall_en;
    logic [N_IN-1:0]  r_status;
    logic [N_OUT-1:0] r_out;
    logic             r_ready;
    logic [31:0]      r_rdata;

    reg_sel_e         w_sel;
    logic             w_wr;
    logic             w_rd;
    logic [N_IN-1:0]  w_wdata_in;
    logic [N_OUT-1:0] w_wdata_out;
    logic [N_IN-1:0]  w_w1c;
    logic [N_IN-1:0]  w_events;
    logic [31:0]      w_rdata;
    logic             w_unused;

    assign w_sel       = reg_sel_e'(io_address[4:2]);
    // A strobe carrying both qualifiers is a write.
    assign w_wr        = io_addr_strobe & io_write_strobe;
    assign w_rd        = io_addr_strobe & io_read_strobe & ~io_write_strobe;
    assign w_wdata_in  = io_write_data[N_IN-1:0];
    assign w_wdata_out = io_write_data[N_OUT-1:0];
    // Address bits outside [4:2] and data bits above the channel width are don't-care.
    assign w_unused    = ^{io_address[31:5], io_address[1:0], io_write_data};

    // Input path: 2-flop synchroniser, then per-bit debounce into r_stable.
    always_ff @(posedge clk_fpga) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            r_prev   <= '0;
            // NOTE: r_cnt is an array of ordinary flops, not a RAM, so it can be reset like any register.
            for (int i = 0; i < N_IN; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= switchs;
            r_sync2 <= r_sync1;
            r_prev  <= r_stable;
            for (int i = 0; i < N_IN; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    // This is the DEBOUNCE_CYCLES-th differing cycle: accept the new level.
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Enabled edges of the debounced value, seen one cycle after r_stable moves.
    assign w_events = (r_stable & ~r_prev & r_rise_en) | (~r_stable & r_prev & r_fall_en);
    assign w_w1c    = (w_wr && w_sel == A_STAT) ? w_wdata_in : '0;

    // Status latch: W1C clears, a coincident edge event wins over the clear.
    always_ff @(posedge clk_fpga) begin
        if (!reset) r_status <= '0;
        else        r_status <= (r_status & ~w_w1c) | w_events;
    end

    // Writable control registers: OUT (with set/clear aliases) and edge enables.
    always_ff @(posedge clk_fpga) begin
        if (!reset) begin
            r_out     <= OUT_RESET;
            r_rise_en <= '0;
            r_fall_en <= '0;
        end else if (w_wr) begin
            case (w_sel)
                A_OUT:   r_out     <= w_wdata_out;
                A_SET:   r_out     <= r_out | w_wdata_out;
                A_CLR:   r_out     <= r_out & ~w_wdata_out;
                A_RISE:  r_rise_en <= w_wdata_in;
                A_FALL:  r_fall_en <= w_wdata_in;
                default: ;
            endcase
        end
    end

    // Read mux; write-only and unmapped addresses return zero.
    always_comb begin
        // NOTE: default assigned first so no path through this block can infer a latch.
        w_rdata = '0;
        if (w_rd) begin
            case (w_sel)
                A_OUT:   w_rdata = 32'(r_out);
                A_IN:    w_rdata = 32'(r_stable);
                A_RISE:  w_rdata = 32'(r_rise_en);
                A_FALL:  w_rdata = 32'(r_fall_en);
                A_STAT:  w_rdata = 32'(r_status);
                default: w_rdata = '0;
            endcase
        end
    end

    // Bus response: every strobe completes with zero wait states on the next cycle.
    always_ff @(posedge clk_fpga) begin
        if (!reset) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= io_addr_strobe;
            r_rdata <= w_rdata;
        end
    end

    // Gating with reset aborts an access whose completion cycle falls inside reset.
    assign io_ready     = r_ready & reset;
    assign io_read_data = io_ready ? r_rdata : '0;
    assign leds         = r_out;
    assign irq          = |r_status;
endmodule

// File: tb/tb_gpio_bank.sv
// Testbench for gpio_bank: directed bus accesses push expected responses into
// per-instance queues; a negedge monitor pops and compares on each io_ready.
module tb_gpio_bank;
    localparam logic [31:0] R_OUT  = 32'h00;
    localparam logic [31:0] R_IN   = 32'h04;
    localparam logic [31:0] R_RISE = 32'h08;
    localparam logic [31:0] R_FALL = 32'h0C;
    localparam logic [31:0] R_STAT = 32'h10;
    localparam logic [31:0] R_SET  = 32'h14;
    localparam logic [31:0] R_CLR  = 32'h18;
    localparam logic [31:0] R_NONE = 32'h1C;

    typedef struct {
        logic        is_read;
        logic [31:0] data;
        int          cyc;
        string       name;
    } exp_t;

    logic        clk_fpga = 1'b0;
    logic        reset;
    logic        as8, rs8, ws8, as32, rs32, ws32;
    logic [31:0] addr8, wd8, rdata8, addr32, wd32, rdata32;
    logic        ready8, ready32, irq8, irq32;
    logic [7:0]  sw8, leds8;
    logic [31:0] sw32, leds32;

    exp_t q8[$];
    exp_t q32[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk_fpga = ~clk_fpga;
    always @(posedge clk_fpga) cyc <= cyc + 1;

    gpio_bank #(.N_IN(8), .N_OUT(8), .DEBOUNCE_CYCLES(16), .OUT_RESET(8'hA5)) dut8 (
        .clk_fpga(clk_fpga), .reset(reset),
        .io_addr_strobe(as8), .io_read_strobe(rs8), .io_write_strobe(ws8),
        .io_address(addr8), .io_write_data(wd8), .io_read_data(rdata8), .io_ready(ready8),
        .switchs(sw8), .leds(leds8), .irq(irq8)
    );

    gpio_bank #(.N_IN(32), .N_OUT(32), .DEBOUNCE_CYCLES(1), .OUT_RESET(32'h8000_0001)) dut32 (
        .clk_fpga(clk_fpga), .reset(reset),
        .io_addr_strobe(as32), .io_read_strobe(rs32), .io_write_strobe(ws32),
        .io_address(addr32), .io_write_data(wd32), .io_read_data(rdata32), .io_ready(ready32),
        .switchs(sw32), .leds(leds32), .irq(irq32)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor_port(input int which, input logic rdy, input logic [31:0] data);
        exp_t e;
        int   pending;
        if (rdy !== 1'b1) return;
        pending = (which == 0) ? q8.size() : q32.size();
        if (pending == 0) begin
            check(which == 0 ? "unexpected_ready8" : "unexpected_ready32", 32'(rdy), 32'd0);
            return;
        end
        if (which == 0) e = q8.pop_front();
        else            e = q32.pop_front();
        check({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
        if (e.is_read) check(e.name, data, e.data);
    endtask

    // Monitor: sample responses on the falling edge, away from the active edge.
    always @(negedge clk_fpga) begin
        monitor_port(0, ready8, rdata8);
        monitor_port(1, ready32, rdata32);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_fpga);
        #1;
    endtask

    task automatic bus(input int which, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_data, input string name,
                       input bit track);
        exp_t e;
        e.is_read = rd & ~wr;
        e.data    = exp_data;
        e.cyc     = cyc + 1;
        e.name    = name;
        if (which == 0) begin
            as8 = 1'b1; rs8 = rd; ws8 = wr; addr8 = a; wd8 = d;
            if (track) q8.push_back(e);
        end else begin
            as32 = 1'b1; rs32 = rd; ws32 = wr; addr32 = a; wd32 = d;
            if (track) q32.push_back(e);
        end
        tick(1);
        as8 = 1'b0; rs8 = 1'b0; ws8 = 1'b0;
        as32 = 1'b0; rs32 = 1'b0; ws32 = 1'b0;
    endtask

    task automatic wr(input int which, input logic [31:0] a, input logic [31:0] d);
        bus(which, 1'b0, 1'b1, a, d, 32'd0, "write", 1'b1);
    endtask

    task automatic rd(input int which, input logic [31:0] a, input logic [31:0] exp_data, input string name);
        bus(which, 1'b1, 1'b0, a, 32'd0, exp_data, name, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        as8 = 1'b0; rs8 = 1'b0; ws8 = 1'b0; addr8 = '0; wd8 = '0; sw8 = '0;
        as32 = 1'b0; rs32 = 1'b0; ws32 = 1'b0; addr32 = '0; wd32 = '0; sw32 = '0;

        // Reset state.
        tick(3);
        check("reset_leds8", 32'(leds8), 32'hA5);
        check("reset_leds32", leds32, 32'h8000_0001);
        check("reset_irq8", 32'(irq8), 32'd0);
        check("reset_ready8", 32'(ready8), 32'd0);
        check("reset_rdata8", rdata8, 32'd0);
        reset = 1'b1;
        rd(0, R_IN, 32'h00, "in_after_reset");
        rd(0, R_OUT, 32'hA5, "out_after_reset");

        // Output path, back-to-back strobes.
        wr(0, R_OUT, 32'h0F);       check("leds_out", 32'(leds8), 32'h0F);
        wr(0, R_SET, 32'hF0);       check("leds_set", 32'(leds8), 32'hFF);
        wr(0, R_CLR, 32'h11);       check("leds_clr", 32'(leds8), 32'hEE);
        rd(0, R_SET, 32'h00, "read_out_set");
        rd(0, R_CLR, 32'h00, "read_out_clr");
        rd(0, R_OUT, 32'hEE, "read_out");
        wr(0, R_OUT, 32'h1234_5600); check("leds_upper_ignored", 32'(leds8), 32'h00);
        rd(0, R_OUT, 32'h00, "read_out_masked");

        // Read immediately after write, dual-qualifier strobe, unmapped address.
        wr(0, R_RISE, 32'h108);
        rd(0, R_RISE, 32'h08, "rise_en_raw");
        bus(0, 1'b1, 1'b1, R_FALL, 32'hFF, 32'd0, "rw_as_write", 1'b1);
        rd(0, R_FALL, 32'hFF, "fall_en_after_rw");
        wr(0, R_FALL, 32'h00);
        rd(0, R_FALL, 32'h00, "fall_en_cleared");
        wr(0, R_NONE, 32'hFFFF_FFFF);
        rd(0, R_NONE, 32'h00, "unmapped_read");
        rd(0, R_OUT, 32'h00, "out_after_unmapped_write");
        rd(0, R_RISE, 32'h08, "rise_after_unmapped_write");

        // Glitch shorter than the debounce window.
        sw8[3] = 1'b1; tick(10);
        sw8[3] = 1'b0; tick(30);
        rd(0, R_IN, 32'h00, "in_after_glitch");
        rd(0, R_STAT, 32'h00, "status_after_glitch");
        check("irq_after_glitch", 32'(irq8), 32'd0);

        // Sustained rise: IN changes exactly 18 cycles later, irq one cycle after.
        sw8[3] = 1'b1; tick(17);
        rd(0, R_IN, 32'h00, "in_before_latency");
        check("irq_before_edge", 32'(irq8), 32'd0);
        rd(0, R_IN, 32'h08, "in_at_latency");
        check("irq_at_edge", 32'(irq8), 32'd1);
        rd(0, R_STAT, 32'h08, "status_rise");

        // Fall with FALL_EN=0 adds nothing; W1C clears irq next cycle.
        sw8[3] = 1'b0; tick(25);
        rd(0, R_IN, 32'h00, "in_after_fall");
        rd(0, R_STAT, 32'h08, "status_after_fall");
        wr(0, R_STAT, 32'h08);
        check("irq_after_w1c", 32'(irq8), 32'd0);
        rd(0, R_STAT, 32'h00, "status_after_w1c");

        // Falling-edge path on bit 2 (rise on bit 2 not enabled).
        wr(0, R_FALL, 32'h04);
        sw8[2] = 1'b1; tick(25);
        rd(0, R_STAT, 32'h00, "status_rise_bit2_masked");
        sw8[2] = 1'b0; tick(25);
        rd(0, R_STAT, 32'h04, "status_fall_bit2");
        check("irq_fall_bit2", 32'(irq8), 32'd1);
        wr(0, R_STAT, 32'h04);
        wr(0, R_FALL, 32'h00);
        check("irq_after_w1c_bit2", 32'(irq8), 32'd0);

        // Collision: W1C lands in the same cycle as a new rising-edge event.
        sw8[3] = 1'b1; tick(25);
        rd(0, R_STAT, 32'h08, "status_before_collision");
        sw8[3] = 1'b0; tick(25);
        sw8[3] = 1'b1; tick(18);
        wr(0, R_STAT, 32'h08);
        check("irq_collision", 32'(irq8), 32'd1);
        rd(0, R_STAT, 32'h08, "status_collision");
        wr(0, R_STAT, 32'h08);
        check("irq_after_collision_clear", 32'(irq8), 32'd0);

        // Reset the cycle after a strobe: no ready pulse; switch held high through reset.
        bus(0, 1'b1, 1'b0, R_OUT, 32'd0, 32'd0, "aborted", 1'b0);
        reset = 1'b0;
        @(negedge clk_fpga);
        check("abort_ready8", 32'(ready8), 32'd0);
        check("abort_rdata8", rdata8, 32'd0);
        tick(3);
        check("rereset_leds8", 32'(leds8), 32'hA5);
        check("rereset_irq8", 32'(irq8), 32'd0);
        reset = 1'b1;
        wr(0, R_RISE, 32'h08);
        tick(25);
        rd(0, R_STAT, 32'h08, "status_held_through_reset");
        check("irq_held_through_reset", 32'(irq8), 32'd1);
        rd(0, R_IN, 32'h08, "in_held_through_reset");

        // 32-bit instance, DEBOUNCE_CYCLES=1.
        check("leds32_after_rereset", leds32, 32'h8000_0001);
        wr(1, R_OUT, 32'hFFFF_0000); check("leds32_out", leds32, 32'hFFFF_0000);
        wr(1, R_CLR, 32'h8000_0000); check("leds32_clr", leds32, 32'h7FFF_0000);
        wr(1, R_SET, 32'h0000_0001); check("leds32_set", leds32, 32'h7FFF_0001);
        rd(1, R_OUT, 32'h7FFF_0001, "out32");
        wr(1, R_RISE, 32'h8000_0000);
        rd(1, R_RISE, 32'h8000_0000, "rise32");
        sw32[31] = 1'b1; tick(2);
        rd(1, R_IN, 32'h0000_0000, "in32_before_latency");
        rd(1, R_IN, 32'h8000_0000, "in32_at_latency");
        check("irq32_edge", 32'(irq32), 32'd1);
        rd(1, R_STAT, 32'h8000_0000, "status32");
        wr(1, R_STAT, 32'hFFFF_FFFF);
        check("irq32_after_w1c", 32'(irq32), 32'd0);
        rd(1, R_STAT, 32'h0000_0000, "status32_after_w1c");
        rd(1, R_NONE, 32'h0000_0000, "unmapped32");

        tick(3);
        check("pending_responses8", 32'(q8.size()), 32'd0);
        check("pending_responses32", 32'(q32.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
